flash_avmm_responder: RTL and testbench



---
 rtl/flash_avmm_responder.sv | 119 +++++++++++
 tb/tb_flash_avmm_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_avmm_responder.sv
// Avalon-MM read responder standing in for the EPCS128 flash word port: wait states, pipelined read latency, backdoor preload.
// Optional build macro FLASH_RESP_JITTER_EN adds LFSR-driven extra wait states per request.
module flash_avmm_responder #(
   parameter int unsigned ADDR_WIDTH   = 23,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned WAIT_STATES  = 2,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  read,
   input  logic [3:0]            byteenable,
   output logic                  waitrequest,
   output logic [DATA_WIDTH-1:0] readdata,
   output logic                  readdatavalid,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CMP_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
`ifdef FLASH_RESP_JITTER_EN
   localparam int unsigned CNT_W = 5;
`else
   localparam int unsigned CNT_W = 4;
`endif

   typedef enum logic [1:0] {IDLE, STALL, ACCEPT} phase_e;

   logic [CNT_W-1:0]      wcnt;
   logic [CNT_W-1:0]      wait_target;
   phase_e                phase;
   logic                  accept;
   logic                  rd_in_range;
   logic                  ld_in_range;
   logic [DATA_WIDTH-1:0] lane_mask;
   logic [DATA_WIDTH-1:0] fetch;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [READ_LATENCY-1:0] vld_pipe;
   logic [DATA_WIDTH-1:0]   dat_pipe [READ_LATENCY];

`ifdef FLASH_RESP_JITTER_EN
   logic [7:0] lfsr;
   logic [1:0] extra;

   // Extra wait for a request is taken from the LFSR while wcnt is 0, then frozen in 'extra'.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr  <= 8'hA5;
         extra <= 2'd0;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         if (phase == IDLE && read && !accept)
            extra <= lfsr[1:0];
      end
   end

   assign wait_target = CNT_W'(WAIT_STATES) + CNT_W'((wcnt == '0) ? lfsr[1:0] : extra);
`else
   assign wait_target = CNT_W'(WAIT_STATES);
`endif

   always_comb begin
      phase = IDLE;
      if (read && wcnt == wait_target)
         phase = ACCEPT;
      else if (wcnt != '0)
         phase = STALL;
   end

   assign accept      = (phase == ACCEPT) && !reset;
   assign waitrequest = reset | (read & (wcnt != wait_target));

   assign rd_in_range = CMP_W'(address)   < CMP_W'(DEPTH);
   assign ld_in_range = CMP_W'(load_addr) < CMP_W'(DEPTH);

   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < 4; i++)
         lane_mask[8*i +: 8] = {8{byteenable[i]}};
   end

   assign fetch = rd_in_range ? (mem[address[IDX_W-1:0]] & lane_mask) : '0;

   // Backdoor port has no reset: contents survive reset and loads work while reset is high.
   always_ff @(posedge clk) begin
      if (load_en && ld_in_range)
         mem[load_addr[IDX_W-1:0]] <= load_data;
   end

   // Wait counter plus the return pipeline; reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt     <= '0;
         vld_pipe <= '0;
         for (int i = 0; i < READ_LATENCY; i++)
            dat_pipe[i] <= '0;
      end else begin
         case (phase)
            IDLE, STALL: wcnt <= read ? wcnt + CNT_W'(1) : '0;
            ACCEPT:      wcnt <= '0;
            default:     wcnt <= '0;
         endcase
         vld_pipe[0] <= accept;
         dat_pipe[0] <= accept ? fetch : '0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            dat_pipe[i] <= dat_pipe[i-1];
         end
      end
   end

   assign readdatavalid = vld_pipe[READ_LATENCY-1];
   assign readdata      = dat_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_flash_avmm_responder.sv
// Bench for flash_avmm_responder: one instance with 2 wait states, one with 0, shared backdoor and reset.
module tb_flash_avmm_responder;

   localparam int unsigned AW  = 23;
   localparam int unsigned DW  = 32;
   localparam int unsigned RL  = 2;
   localparam int unsigned WS0 = 2;
   localparam int unsigned WS1 = 0;

   logic          clk = 1'b0;
   logic          reset;
   logic          rd0, rd1;
   logic [AW-1:0] a0, a1;
   logic [3:0]    be0, be1;
   logic          wr0, wr1, v0, v1;
   logic [DW-1:0] d0, d1;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [DW-1:0] load_data;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;

   typedef struct {logic [DW-1:0] data; int unsigned cyc;} exp_t;
   typedef struct {logic [AW-1:0] addr; logic [3:0] be; logic [DW-1:0] data;} vec_t;
   exp_t q0[$];
   exp_t q1[$];
   vec_t vecs[8];

   flash_avmm_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(1024),
                          .WAIT_STATES(WS0), .READ_LATENCY(RL)) u_dut0 (
      .clk(clk), .reset(reset), .address(a0), .read(rd0), .byteenable(be0),
      .waitrequest(wr0), .readdata(d0), .readdatavalid(v0),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

   flash_avmm_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(1024),
                          .WAIT_STATES(WS1), .READ_LATENCY(RL)) u_dut1 (
      .clk(clk), .reset(reset), .address(a1), .read(rd1), .byteenable(be1),
      .waitrequest(wr1), .readdata(d1), .readdatavalid(v1),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboard: every valid pulse must match the oldest expectation in data and arrival cycle.
   always @(negedge clk) begin
      exp_t e;
      if (v0) begin
         check("dut0_valid_expected", 32'(q0.size() > 0), 32'd1);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check("dut0_data", d0, e.data);
            check("dut0_latency", cyc, e.cyc);
         end
      end else
         check("dut0_idle_data", d0, '0);
      if (v1) begin
         check("dut1_valid_expected", 32'(q1.size() > 0), 32'd1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("dut1_data", d1, e.data);
            check("dut1_latency", cyc, e.cyc);
         end
      end else
         check("dut1_idle_data", d1, '0);
   end

   task automatic set_req(input int which, input logic r, input logic [AW-1:0] a, input logic [3:0] b);
      if (which == 0) begin rd0 = r; a0 = a; be0 = b; end
      else            begin rd1 = r; a1 = a; be1 = b; end
   endtask

   task automatic push(input int which, input logic [DW-1:0] data);
      exp_t e;
      e.data = data;
      e.cyc  = cyc + RL - 1;
      if (which == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      @(posedge clk); #1;
      load_en = 1'b0;
   endtask

   // Holds read until accepted (bounded), checks the stall length, queues the expected return.
   task automatic do_read(input int which, input logic [AW-1:0] addr, input logic [3:0] b,
                          input logic [DW-1:0] exp, input int unsigned exp_wait, input bit expect_ret,
                          output int unsigned waits);
      bit acc = 1'b0;
      waits = 0;
      set_req(which, 1'b1, addr, b);
      for (int i = 0; i < 40 && !acc; i++) begin
         @(negedge clk);
         if (!((which == 0) ? wr0 : wr1)) acc = 1'b1;
         else waits++;
         @(posedge clk); #1;
      end
      set_req(which, 1'b0, '0, '0);
      check("read_accepted", 32'(acc), 32'd1);
      if (acc) begin
`ifdef FLASH_RESP_JITTER_EN
         check("wait_range", 32'(waits >= exp_wait && waits <= exp_wait + 3), 32'd1);
`else
         check("wait_count", waits, exp_wait);
`endif
         if (expect_ret) push(which, exp);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (q0.size() > 0 || q1.size() > 0); i++) begin
         @(posedge clk); #1;
      end
      check("drain_empty", 32'(q0.size() + q1.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish before timeout");
      $fatal(1);
   end

   initial begin
      int unsigned w;
`ifdef FLASH_RESP_JITTER_EN
      int unsigned wseq[16];
`endif
      reset = 1'b1;
      rd0 = 1'b0; rd1 = 1'b0; a0 = '0; a1 = '0; be0 = '0; be1 = '0;
      load_en = 1'b0; load_addr = '0; load_data = '0;

      vecs[0] = '{23'd100,  4'hF,    32'h03020100};
      vecs[1] = '{23'd101,  4'b0101, 32'h00060004};
      vecs[2] = '{23'd101,  4'h0,    32'h00000000};
      vecs[3] = '{23'd2000, 4'hF,    32'h00000000};
      vecs[4] = '{23'd102,  4'b1010, 32'h0B000900};
      vecs[5] = '{23'd102,  4'hF,    32'h0B0A0908};
      vecs[6] = '{23'd1124, 4'hF,    32'h00000000};
      vecs[7] = '{23'd100,  4'b0011, 32'h00000100};

      @(posedge clk); #1;
      // Preload while reset is still high; the out-of-range load must not alias onto word 100.
      load(23'd100,  32'h03020100);
      load(23'd101,  32'h07060504);
      load(23'd102,  32'h0B0A0908);
      load(23'd1124, 32'hDEADBEEF);
      @(negedge clk);
      check("reset_waitrequest0", 32'(wr0), 32'd1);
      check("reset_waitrequest1", 32'(wr1), 32'd1);
      check("reset_valid0", 32'(v0), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("idle_waitrequest0", 32'(wr0), 32'd0);
      check("idle_waitrequest1", 32'(wr1), 32'd0);
      @(posedge clk); #1;

      for (int which = 0; which < 2; which++) begin
         for (int i = 0; i < 8; i++)
            do_read(which, vecs[i].addr, vecs[i].be, vecs[i].data,
                    (which == 0) ? WS0 : WS1, 1'b1, w);
         drain();
      end

      // Abandoned request: nothing returned, and the next request restarts the full count.
      set_req(0, 1'b1, 23'd100, 4'hF);
      @(negedge clk);
      check("abandon_waitrequest", 32'(wr0), 32'd1);
      @(posedge clk); #1;
      set_req(0, 1'b0, '0, '0);
      @(posedge clk); #1;
      do_read(0, 23'd101, 4'hF, 32'h07060504, WS0, 1'b1, w);
      drain();

`ifndef FLASH_RESP_JITTER_EN
      // Zero wait states: accepts on three consecutive cycles, three consecutive returns.
      for (int i = 0; i < 3; i++) begin
         set_req(1, 1'b1, AW'(100 + i), 4'hF);
         @(negedge clk);
         check("b2b_waitrequest", 32'(wr1), 32'd0);
         @(posedge clk); #1;
         push(1, (i == 0) ? 32'h03020100 : (i == 1) ? 32'h07060504 : 32'h0B0A0908);
      end
      set_req(1, 1'b0, '0, '0);
      drain();

      // Load and accepted read to the same word on the same edge: the read sees the old word.
      set_req(1, 1'b1, 23'd100, 4'hF);
      load_en = 1'b1; load_addr = 23'd100; load_data = 32'hAAAA5555;
      @(negedge clk);
      check("collide_waitrequest", 32'(wr1), 32'd0);
      @(posedge clk); #1;
      load_en = 1'b0;
      push(1, 32'h03020100);
      do_read(1, 23'd100, 4'hF, 32'hAAAA5555, WS1, 1'b1, w);
      drain();
`endif

      // Reset one cycle after acceptance flushes the in-flight read.
      do_read(0, 23'd101, 4'hF, 32'h0, WS0, 1'b0, w);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_waitrequest0", 32'(wr0), 32'd1);
      check("midreset_waitrequest1", 32'(wr1), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      do_read(0, 23'd101, 4'hF, 32'h07060504, WS0, 1'b1, w);
      drain();

`ifdef FLASH_RESP_JITTER_EN
      // The jitter sequence must repeat exactly after a reset reseeds the LFSR.
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      for (int i = 0; i < 16; i++)
         do_read(0, 23'd102, 4'hF, 32'h0B0A0908, WS0, 1'b1, wseq[i]);
      drain();
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         do_read(0, 23'd102, 4'hF, 32'h0B0A0908, WS0, 1'b1, w);
         check("jitter_repeat", w, wseq[i]);
      end
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
